// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x4 keypad scan sequencer: matrix geometry,
// scan FSM state encoding, key code type, the idle column drive pattern
// and the lowest-index priority encoder used by the event picker.
package keypad_pkg;

    localparam int N_COLS = 4;
    localparam int N_ROWS = 4;
    localparam int N_KEYS = 16;

    typedef enum logic [1:0] {
        DRIVE   = 2'd0,
        SAMPLE  = 2'd1,
        COMPARE = 2'd2
    } scan_state_t;

    // Key code layout is {col[1:0], row[1:0]}, which equals the bit index
    // of the key in the 16-bit matrix masks.
    typedef logic [3:0] key_code_t;

    // All columns released (active-low drive).
    localparam logic [N_COLS-1:0] COL_IDLE = 4'b1111;

    // Index of the lowest set bit; returns 0 for an empty mask, so callers
    // must qualify the result with a non-empty test.
    function automatic key_code_t lowest_index(input logic [N_KEYS-1:0] mask);
        key_code_t idx;
        idx = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (mask[i]) idx = key_code_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_event_picker.sv
// keypad_event_picker
// Holds the pending press (and optionally release) masks, picks the
// lowest-index pending key and presents it on a valid/ack output register.
//
// Optional build macro: KEYPAD_RELEASE_EVT_EN
//   defined   - release edges are tracked in a second pending mask and are
//               reported (key_rel=1) after all pending presses.
//   undefined - only presses are reported; key_rel is held at 0.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         debounced matrix accepted this cycle; merge the set masks
//   press_set    keys that went from released to held at this acceptance
//   rel_set      keys that went from held to released at this acceptance
//   key_ack      consumer accepts the event when key_valid && key_ack
//   key_valid    event available
//   key_code     index of the event key, stable while key_valid
//   key_rel      event is a release
module keypad_event_picker
    import keypad_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [N_KEYS-1:0] press_set,
    input  logic [N_KEYS-1:0] rel_set,
    input  logic              key_ack,
    output logic              key_valid,
    output key_code_t         key_code,
    output logic              key_rel
);

    logic [N_KEYS-1:0] pending;
    logic [N_KEYS-1:0] press_clr;
    logic              have_press;
    logic              have_any;
    logic              take;
    key_code_t         pick_code;
    logic              pick_rel;

`ifdef KEYPAD_RELEASE_EVT_EN
    logic [N_KEYS-1:0] rel_pending;
    logic [N_KEYS-1:0] rel_clr;
`else
    logic unused_rel;
    assign unused_rel = ^rel_set;
`endif

    // The output register is free to take a new event when it is empty or
    // its current event is being acknowledged this cycle; this gives
    // back-to-back events without a bubble.
    assign take = !key_valid || key_ack;

    always_comb begin
        have_press = |pending;
        press_clr  = '0;
`ifdef KEYPAD_RELEASE_EVT_EN
        rel_clr  = '0;
        have_any = have_press || (|rel_pending);
        // Presses always win over releases; within a class, lowest index.
        if (have_press) begin
            pick_code = lowest_index(pending);
            pick_rel  = 1'b0;
        end else begin
            pick_code = lowest_index(rel_pending);
            pick_rel  = 1'b1;
        end
        if (take && have_any) begin
            if (have_press) press_clr[pick_code] = 1'b1;
            else            rel_clr[pick_code]   = 1'b1;
        end
`else
        have_any  = have_press;
        pick_code = lowest_index(pending);
        pick_rel  = 1'b0;
        if (take && have_any) press_clr[pick_code] = 1'b1;
`endif
    end

    // Clear-then-merge: a key accepted again while still pending simply
    // stays set, so there are no duplicates and nothing can overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~press_clr) | (load ? press_set : '0);
        end
    end

`ifdef KEYPAD_RELEASE_EVT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rel_pending <= '0;
        end else begin
            rel_pending <= (rel_pending & ~rel_clr) | (load ? rel_set : '0);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid <= 1'b0;
            key_code  <= '0;
            key_rel   <= 1'b0;
        end else if (take) begin
            if (have_any) begin
                key_valid <= 1'b1;
                key_code  <= pick_code;
                key_rel   <= pick_rel;
            end else begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/keypad_scan_sequencer.sv
// keypad_scan_sequencer
// Scans a 4x4 keypad column by column (active-low column drive), samples
// the synchronized row lines, debounces the whole 16-key matrix once per
// scan and hands press events to the game logic one at a time over a
// valid/ack handshake. Scan period is 4*(SETTLE_CYCLES+1)+1 cycles.
//
// Optional build macro: KEYPAD_RELEASE_EVT_EN (release events, see
// keypad_event_picker).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   col_n      column drive, active-low one-hot, 4'b1111 while comparing
//   row        raw asynchronous row lines, active-high
//   key_valid  event available
//   key_code   {col, row} of the event, stable while key_valid
//   key_rel    event is a release (0 unless KEYPAD_RELEASE_EVT_EN)
//   key_ack    event accepted when key_valid && key_ack at a rising edge
//   key_state  debounced matrix, bit col*4+row
module keypad_scan_sequencer
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [N_COLS-1:0] col_n,
    input  logic [N_ROWS-1:0] row,
    output logic              key_valid,
    output key_code_t         key_code,
    output logic              key_rel,
    input  logic              key_ack,
    output logic [N_KEYS-1:0] key_state
);

    // The stability counter only needs to reach DEBOUNCE_SCANS-1, the
    // acceptance threshold, so it saturates there.
    localparam int STAB_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX    = STAB_W'(DEBOUNCE_SCANS - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    scan_state_t       state, state_nx;
    logic [1:0]        col, col_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [N_ROWS-1:0] row_s1, row_s2;
    logic [N_KEYS-1:0] raw, prev_raw;
    logic [STAB_W-1:0] stable_cnt, stable_nx;
    logic              accept;
    logic [N_KEYS-1:0] press_set, rel_set;

    // Two-flop synchronizer; the settle time covers its latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1 <= '0;
            row_s2 <= '0;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DRIVE;
            col   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            col   <= col_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        col_nx   = col;
        cnt_nx   = cnt;
        col_n    = COL_IDLE;
        if (state != COMPARE) col_n[col] = 1'b0;

        case (state)
            DRIVE: begin
                if (cnt == SETTLE_LAST) begin
                    state_nx = SAMPLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            SAMPLE: begin
                cnt_nx = '0;
                if (col == 2'd3) begin
                    state_nx = COMPARE;
                end else begin
                    col_nx   = col + 1'b1;
                    state_nx = DRIVE;
                end
            end
            COMPARE: begin
                col_nx   = '0;
                cnt_nx   = '0;
                state_nx = DRIVE;
            end
            default: begin
                col_nx   = '0;
                cnt_nx   = '0;
                state_nx = DRIVE;
            end
        endcase
    end

    // Debounce: a matrix is accepted once it has repeated unchanged for
    // DEBOUNCE_SCANS consecutive scans.
    always_comb begin
        if (raw == prev_raw) begin
            stable_nx = (stable_cnt == STAB_MAX) ? stable_cnt : stable_cnt + 1'b1;
        end else begin
            stable_nx = '0;
        end
        accept    = (state == COMPARE) && (stable_nx >= STAB_MAX);
        press_set = raw & ~key_state;
        rel_set   = key_state & ~raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw        <= '0;
            prev_raw   <= '0;
            stable_cnt <= '0;
            key_state  <= '0;
        end else begin
            if (state == SAMPLE) begin
                raw[{col, 2'b00} +: N_ROWS] <= row_s2;
            end
            if (state == COMPARE) begin
                stable_cnt <= stable_nx;
                prev_raw   <= raw;
                if (accept) key_state <= raw;
            end
        end
    end

    keypad_event_picker u_picker (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .press_set (press_set),
        .rel_set   (rel_set),
        .key_ack   (key_ack),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_rel   (key_rel)
    );

endmodule

// File: tb/tb_keypad_scan_sequencer.sv
// tb_keypad_scan_sequencer
// Directed bench for keypad_scan_sequencer with SETTLE_CYCLES=4 and
// DEBOUNCE_SCANS=2 (21-cycle scan). A behavioural keypad drives row from
// col_n and a mask of physically held keys. Build with
// KEYPAD_RELEASE_EVT_EN defined to include the release-event sequence.
module tb_keypad_scan_sequencer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  col_n;
    logic [3:0]  row;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_rel;
    logic        key_ack;
    logic [15:0] key_state;
    logic [15:0] pressed;

    int n_tests;
    int n_fail;
    int cyc;

    keypad_scan_sequencer #(
        .SETTLE_CYCLES  (4),
        .DEBOUNCE_SCANS (2),
        .CNT_W          (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_n     (col_n),
        .row       (row),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_rel   (key_rel),
        .key_ack   (key_ack),
        .key_state (key_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a held key connects its column to its row.
    always_comb begin
        row = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (pressed[i*4+j] && !col_n[i]) row[j] = 1'b1;
            end
        end
    end

    typedef struct {
        int          col;
        int          rown;
        logic [15:0] exp_state;
        logic [3:0]  exp_code;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic step_to(input int target);
        step(target - cyc);
    endtask

    // After this, cyc counts rising edges since reset release.
    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        key_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        logic [3:0] exp_col;
        int p;
        int rep;

        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        key_ack = 1'b0;
        pressed = '0;

        vecs[0] = '{1, 2, 16'h0040, 4'h6};
        vecs[1] = '{0, 0, 16'h0001, 4'h0};
        vecs[2] = '{3, 3, 16'h8000, 4'hF};
        vecs[3] = '{2, 1, 16'h0200, 4'h9};
        vecs[4] = '{3, 0, 16'h1000, 4'hC};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_col_n", col_n, 4'b1110);
        check("rst_valid", key_valid, 1'b0);
        check("rst_code", key_code, 4'h0);
        check("rst_rel", key_rel, 1'b0);
        check("rst_state", key_state, 16'h0000);

        // Idle scan pattern over two scans
        do_reset();
        for (int k = 0; k < 42; k++) begin
            p = k % 21;
            if (p == 20) exp_col = 4'b1111;
            else         exp_col = ~(4'b0001 << (p / 5));
            check($sformatf("idle_col_n_c%0d", k), col_n, exp_col);
            step(1);
        end
        check("idle_valid", key_valid, 1'b0);
        check("idle_state", key_state, 16'h0000);

        // Single key presses, table-driven
        for (int i = 0; i < 5; i++) begin
            pressed = '0;
            pressed[vecs[i].col*4 + vecs[i].rown] = 1'b1;
            do_reset();
            step_to(42);
            check($sformatf("vec%0d_state_accept", i), key_state, vecs[i].exp_state);
            check($sformatf("vec%0d_valid_before", i), key_valid, 1'b0);
            step_to(43);
            check($sformatf("vec%0d_valid", i), key_valid, 1'b1);
            check($sformatf("vec%0d_code", i), key_code, vecs[i].exp_code);
            check($sformatf("vec%0d_rel", i), key_rel, 1'b0);
            key_ack = 1'b1;
            step(1);
            key_ack = 1'b0;
            check($sformatf("vec%0d_valid_after_ack", i), key_valid, 1'b0);
            rep = 0;
            repeat (42) begin
                step(1);
                if (key_valid) rep++;
            end
            check($sformatf("vec%0d_no_repeat", i), rep, 0);
        end

        // Simultaneous presses with ack held: back-to-back events
        pressed = 16'h1008;
        do_reset();
        key_ack = 1'b1;
        step_to(43);
        check("b2b_valid0", key_valid, 1'b1);
        check("b2b_code0", key_code, 4'h3);
        step(1);
        check("b2b_valid1", key_valid, 1'b1);
        check("b2b_code1", key_code, 4'hC);
        step(1);
        check("b2b_valid_drop", key_valid, 1'b0);
        check("b2b_state", key_state, 16'h1008);
        key_ack = 1'b0;

        // Bounce: key toggles every scan, never stable for two scans
        pressed = 16'h0020;
        do_reset();
        rep = 0;
        for (int s = 0; s < 8; s++) begin
            repeat (21) begin
                step(1);
                if (key_valid || key_state != 16'h0000) rep++;
            end
            pressed = pressed ^ 16'h0020;
        end
        check("bounce_quiet", rep, 0);

        // Reset mid-DRIVE with an event outstanding
        pressed = 16'h0040;
        do_reset();
        step_to(44);
        check("midrst_pre_valid", key_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", key_valid, 1'b0);
        check("midrst_code", key_code, 4'h0);
        check("midrst_rel", key_rel, 1'b0);
        check("midrst_state", key_state, 16'h0000);
        check("midrst_col_n", col_n, 4'b1110);
        pressed = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        rep   = 0;
        repeat (63) begin
            step(1);
            if (key_valid || key_state != 16'h0000) rep++;
        end
        check("midrst_no_event", rep, 0);

`ifdef KEYPAD_RELEASE_EVT_EN
        // Press then release key 0x6
        pressed = 16'h0040;
        do_reset();
        step_to(43);
        check("rel_press_valid", key_valid, 1'b1);
        check("rel_press_code", key_code, 4'h6);
        check("rel_press_rel", key_rel, 1'b0);
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
        check("rel_press_drop", key_valid, 1'b0);
        step_to(63);
        pressed = '0;
        step_to(105);
        check("rel_before", key_valid, 1'b0);
        check("rel_state", key_state, 16'h0000);
        step_to(106);
        check("rel_valid", key_valid, 1'b1);
        check("rel_code", key_code, 4'h6);
        check("rel_flag", key_rel, 1'b1);
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
        check("rel_drop", key_valid, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
